hc259_seq: RTL and testbench

Write sequencer for one HC259 8-bit addressable output latch in the MC14500 computer. Accepts single-bit, full-byte and clear requests from the host through a req/ready/done handshake. Generates the latch's D, A, Eb and CLRb strobes with explicit setup, strobe and hold phases. Keeps a shadow copy of the latch contents for readback and for skipping unchanged bits.

---
 rtl/hc259_seq.sv | 237 +++++++++++++++++++++++
 tb/tb_hc259_seq.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hc259_seq.sv
// Write sequencer for one HC259 addressable latch: bit, byte and clear requests with a shadow copy.
// Latency: bit write done at T0+4, byte write 3k+1 for k strobed bits, clear CLR_CYC+1, skipped/no-op 1.
// Backpressure: ready is high only in IDLE; requests while busy are dropped, not queued.
module hc259_seq #(
  parameter int CLR_CYC        = 2,
  parameter bit SKIP_UNCHANGED = 1'b1
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       req,
  input  logic [1:0] op,
  input  logic [2:0] waddr,
  input  logic       bitval,
  input  logic [7:0] wdata,
  output logic       ready,
  output logic       done,
  output logic [7:0] shadow,
  output logic       lat_D,
  output logic [2:0] lat_A,
  output logic       lat_Eb,
  output logic       lat_CLRb
);

  // Counter wide enough to hold CLR_CYC itself.
  localparam int            CW       = (CLR_CYC < 2) ? 1 : $clog2(CLR_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLR_CYC);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [1:0] OP_BIT  = 2'b00;
  localparam logic [1:0] OP_BYTE = 2'b01;
  localparam logic [1:0] OP_CLR  = 2'b10;

  typedef enum logic [2:0] {
    S_RSTCLR,
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_CLEAR
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_mask;
  logic [7:0]    r_val;
  logic [2:0]    r_idx;
  logic [7:0]    r_shadow;
  logic          r_ready;
  logic          r_done;
  logic          r_d;
  logic [2:0]    r_a;
  logic          r_eb;
  logic          r_clrb;

  state_t        w_state;
  logic [CW-1:0] w_cnt;
  logic [7:0]    w_mask;
  logic [7:0]    w_val;
  logic [2:0]    w_idx;
  logic [7:0]    w_shadow;
  logic          w_done;
  logic          w_d;
  logic [2:0]    w_a;
  logic          w_eb;
  logic          w_clrb;

  logic [7:0]    w_acc_val;
  logic [7:0]    w_acc_raw;
  logic [7:0]    w_acc_mask;
  logic [2:0]    w_acc_idx;
  logic [7:0]    w_rem_mask;
  logic [2:0]    w_rem_idx;

  // Lowest set bit of a mask; bits are strobed in ascending address order.
  function automatic logic [2:0] f_lowest(input logic [7:0] m);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Work mask and target byte computed from the live request inputs at accept.
  // A bit write replicates bitval so r_val[idx] is valid whatever idx is.
  always_comb begin
    w_acc_val = (op == OP_BIT) ? {8{bitval}} : wdata;
    w_acc_raw = (op == OP_BIT) ? (8'b1 << waddr) : 8'hFF;
    if (SKIP_UNCHANGED) begin
      w_acc_mask = w_acc_raw & (w_acc_val ^ r_shadow);
    end else begin
      w_acc_mask = w_acc_raw;
    end
    w_acc_idx  = f_lowest(w_acc_mask);
    w_rem_mask = r_mask & ~(8'b1 << r_idx);
    w_rem_idx  = f_lowest(w_rem_mask);
  end

  // Next-state and next-output logic; strobes default inactive.
  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_mask   = r_mask;
    w_val    = r_val;
    w_idx    = r_idx;
    w_shadow = r_shadow;
    w_done   = 1'b0;
    w_d      = r_d;
    w_a      = r_a;
    w_eb     = 1'b1;
    w_clrb   = 1'b1;

    case (r_state)
      // Post-reset clear: counts from 0 because the first edge after
      // release is the first full cycle of the clear.
      S_RSTCLR: begin
        if (r_cnt == CNT_LAST) begin
          w_state = S_IDLE;
          w_cnt   = '0;
        end else begin
          w_clrb = 1'b0;
          w_cnt  = r_cnt + 1'b1;
        end
      end

      S_IDLE: begin
        if (req) begin
          case (op)
            // The accept edge already starts the first clear cycle, so count from 1.
            OP_CLR: begin
              w_state  = S_CLEAR;
              w_clrb   = 1'b0;
              w_shadow = 8'h00;
              w_cnt    = CNT_ONE;
            end
            OP_BIT, OP_BYTE: begin
              w_val = w_acc_val;
              if (w_acc_mask == 8'h00) begin
                w_done = 1'b1;
              end else begin
                w_state = S_SETUP;
                w_mask  = w_acc_mask;
                w_idx   = w_acc_idx;
                w_a     = w_acc_idx;
                w_d     = w_acc_val[w_acc_idx];
              end
            end
            default: begin
              w_done = 1'b1;
            end
          endcase
        end
      end

      S_SETUP: begin
        w_state = S_STROBE;
        w_eb    = 1'b0;
      end

      S_STROBE: begin
        w_state = S_HOLD;
      end

      // A/D move only here, on the way back to SETUP, with Eb already high.
      S_HOLD: begin
        w_shadow[r_idx] = r_val[r_idx];
        w_mask          = w_rem_mask;
        if (w_rem_mask == 8'h00) begin
          w_state = S_IDLE;
          w_done  = 1'b1;
        end else begin
          w_state = S_SETUP;
          w_idx   = w_rem_idx;
          w_a     = w_rem_idx;
          w_d     = r_val[w_rem_idx];
        end
      end

      S_CLEAR: begin
        if (r_cnt == CNT_LAST) begin
          w_state = S_IDLE;
          w_done  = 1'b1;
          w_cnt   = '0;
        end else begin
          w_clrb = 1'b0;
          w_cnt  = r_cnt + 1'b1;
        end
      end

      default: begin
        w_state = S_RSTCLR;
        w_clrb  = 1'b0;
        w_cnt   = '0;
      end
    endcase
  end

  // State, datapath and registered outputs; reset aborts anything in flight and clears the latch.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state  <= S_RSTCLR;
      r_cnt    <= '0;
      r_mask   <= 8'h00;
      r_val    <= 8'h00;
      r_idx    <= 3'd0;
      r_shadow <= 8'h00;
      r_ready  <= 1'b0;
      r_done   <= 1'b0;
      r_d      <= 1'b0;
      r_a      <= 3'd0;
      r_eb     <= 1'b1;
      r_clrb   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_mask   <= w_mask;
      r_val    <= w_val;
      r_idx    <= w_idx;
      r_shadow <= w_shadow;
      r_ready  <= (w_state == S_IDLE);
      r_done   <= w_done;
      r_d      <= w_d;
      r_a      <= w_a;
      r_eb     <= w_eb;
      r_clrb   <= w_clrb;
    end
  end

  assign ready    = r_ready;
  assign done     = r_done;
  assign shadow   = r_shadow;
  assign lat_D    = r_d;
  assign lat_A    = r_a;
  assign lat_Eb   = r_eb;
  assign lat_CLRb = r_clrb;

endmodule

// File: tb/tb_hc259_seq.sv
// Bench for hc259_seq: directed bit/byte/clear/reset cases plus a modelled random mix.
// Two instances share the request inputs: u_dut skips unchanged bits, u_noskip does not.
// Outputs of the selected instance drive an HC259 latch model and invariant monitor.
module tb_hc259_seq;

  logic       clk = 1'b0;
  logic       rstb;
  logic       req;
  logic [1:0] op;
  logic [2:0] waddr;
  logic       bitval;
  logic [7:0] wdata;
  logic       sel;

  logic       ready0, done0, d0, eb0, clrb0;
  logic [7:0] sh0;
  logic [2:0] a0;
  logic       ready1, done1, d1, eb1, clrb1;
  logic [7:0] sh1;
  logic [2:0] a1;

  logic       ready_m, done_m, d_m, eb_m, clrb_m;
  logic [7:0] sh_m;
  logic [2:0] a_m;

  always #5 clk = ~clk;

  hc259_seq #(.CLR_CYC(2), .SKIP_UNCHANGED(1'b1)) u_dut (
    .clk(clk), .rstb(rstb), .req(req), .op(op), .waddr(waddr), .bitval(bitval), .wdata(wdata),
    .ready(ready0), .done(done0), .shadow(sh0), .lat_D(d0), .lat_A(a0), .lat_Eb(eb0), .lat_CLRb(clrb0)
  );

  hc259_seq #(.CLR_CYC(2), .SKIP_UNCHANGED(1'b0)) u_noskip (
    .clk(clk), .rstb(rstb), .req(req), .op(op), .waddr(waddr), .bitval(bitval), .wdata(wdata),
    .ready(ready1), .done(done1), .shadow(sh1), .lat_D(d1), .lat_A(a1), .lat_Eb(eb1), .lat_CLRb(clrb1)
  );

  assign ready_m = sel ? ready1 : ready0;
  assign done_m  = sel ? done1  : done0;
  assign sh_m    = sel ? sh1    : sh0;
  assign d_m     = sel ? d1     : d0;
  assign a_m     = sel ? a1     : a0;
  assign eb_m    = sel ? eb1    : eb0;
  assign clrb_m  = sel ? clrb1  : clrb0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // HC259 model (captures on Eb falling edge, cleared while CLRb low) and invariants.
  logic [7:0] q;
  logic       mon_en = 1'b0;
  logic       p_eb = 1'b1;
  logic [2:0] p_a = 3'd0;
  logic       p_d = 1'b0;
  int         viol_ad = 0;
  int         viol_both = 0;
  int         viol_sh = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (!clrb_m) q <= 8'h00;
      else if (p_eb && !eb_m) q[a_m] <= d_m;
      if (!eb_m && (a_m !== p_a || d_m !== p_d)) viol_ad <= viol_ad + 1;
      if (!eb_m && !clrb_m) viol_both <= viol_both + 1;
      if (rstb && ready_m && (sh_m !== q)) viol_sh <= viol_sh + 1;
      p_eb <= eb_m;
      p_a  <= a_m;
      p_d  <= d_m;
    end
  end

  logic       tr_eb [0:63];
  logic [2:0] tr_a  [0:63];
  logic       tr_d  [0:63];
  logic [2:0] st_a  [0:15];
  int         n_str, n_clr, n_ebl;

  // Issue one request from a negedge; returns the cycle of done (cycle 1 = T0..T1), -1 on timeout.
  task automatic run_op(input logic [1:0] o, input logic [2:0] a, input logic b,
                        input logic [7:0] d, output int dc);
    logic pe;
    int   w;
    w = 0;
    while (!ready_m && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!ready_m) chk("ready_before_op", ready_m, 1);
    req = 1'b1; op = o; waddr = a; bitval = b; wdata = d;
    n_str = 0; n_clr = 0; n_ebl = 0; pe = 1'b1; dc = -1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; op = ~o; waddr = ~a; bitval = ~b; wdata = ~d;
    for (int n = 1; n < 64; n++) begin
      tr_eb[n] = eb_m; tr_a[n] = a_m; tr_d[n] = d_m;
      if (!eb_m) n_ebl++;
      if (!clrb_m) n_clr++;
      if (pe && !eb_m) begin
        if (n_str < 16) st_a[n_str] = a_m;
        n_str++;
      end
      pe = eb_m;
      if (done_m) begin
        dc = n;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Pulse reset from a negedge, check reset values and the post-reset clear timing.
  task automatic apply_reset(input logic new_sel);
    int first_rdy, nclr, ndone;
    #2 rstb = 1'b0;
    #1;
    chk("rst_clrb", clrb_m, 0);
    chk("rst_eb", eb_m, 1);
    chk("rst_a", a_m, 0);
    chk("rst_d", d_m, 0);
    chk("rst_ready", ready_m, 0);
    chk("rst_done", done_m, 0);
    chk("rst_shadow", sh_m, 0);
    mon_en = 1'b1;
    sel = new_sel;
    req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstb = 1'b1;
    first_rdy = -1; nclr = 0; ndone = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (!clrb_m) nclr++;
      if (done_m) ndone++;
      if (ready_m && first_rdy < 0) first_rdy = n;
    end
    chk("rst_ready_cycle", first_rdy, 3);
    chk("rst_clrb_cycles", nclr, 2);
    chk("rst_no_done", ndone, 0);
    chk("rst_shadow_after", sh_m, 0);
    chk("rst_q_after", q, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  logic [7:0] m_sh, m_mask, m_val;
  logic [1:0] r_o;
  logic [2:0] r_a;
  logic       r_b;
  logic [7:0] r_d;
  int         dc, exp_dc, k;
  logic [2:0] exp_st [0:3];

  initial begin
    rstb = 1'b1; req = 1'b0; op = 2'b11; waddr = 3'd0; bitval = 1'b0; wdata = 8'h00; sel = 1'b0;
    @(negedge clk);
    apply_reset(1'b0);

    // Single bit write: A/D stable for three cycles, one-cycle strobe.
    run_op(2'b00, 3'd5, 1'b1, 8'h00, dc);
    chk("bit_done_cycle", dc, 4);
    for (int n = 1; n <= 3; n++) begin
      chk("bit_addr", tr_a[n], 5);
      chk("bit_data", tr_d[n], 1);
    end
    chk("bit_eb_setup", tr_eb[1], 1);
    chk("bit_eb_strobe", tr_eb[2], 0);
    chk("bit_eb_hold", tr_eb[3], 1);
    chk("bit_strobes", n_str, 1);
    chk("bit_shadow", sh_m, 8'h20);
    chk("bit_q", q, 8'h20);

    // Byte A5 over 20: bit 5 already set, so only 0,2,7 change.
    run_op(2'b01, 3'd0, 1'b0, 8'hA5, dc);
    chk("byte_a5_over20_done", dc, 10);
    chk("byte_a5_over20_strobes", n_str, 3);
    chk("byte_a5_over20_a0", st_a[0], 0);
    chk("byte_a5_over20_a1", st_a[1], 2);
    chk("byte_a5_over20_a2", st_a[2], 7);
    chk("byte_a5_over20_shadow", sh_m, 8'hA5);
    chk("byte_a5_over20_q", q, 8'hA5);

    // Unchanged byte, no-op and unchanged bit all finish in cycle 1 without strobes.
    run_op(2'b01, 3'd0, 1'b0, 8'hA5, dc);
    chk("same_byte_done", dc, 1);
    chk("same_byte_eb_low", n_ebl, 0);
    run_op(2'b11, 3'd3, 1'b1, 8'h00, dc);
    chk("nop_done", dc, 1);
    chk("nop_shadow", sh_m, 8'hA5);
    run_op(2'b00, 3'd0, 1'b1, 8'h00, dc);
    chk("same_bit_done", dc, 1);
    chk("same_bit_eb_low", n_ebl, 0);

    // Clearing a single bit.
    run_op(2'b00, 3'd7, 1'b0, 8'h00, dc);
    chk("bit7_clr_done", dc, 4);
    chk("bit7_clr_shadow", sh_m, 8'h25);
    chk("bit7_clr_q", q, 8'h25);

    // Clear op.
    run_op(2'b10, 3'd0, 1'b0, 8'h00, dc);
    chk("clear_done", dc, 3);
    chk("clear_clrb_cycles", n_clr, 2);
    chk("clear_eb_low", n_ebl, 0);
    chk("clear_shadow", sh_m, 8'h00);
    chk("clear_q", q, 8'h00);

    // Byte A5 from zero: strobes at 0,2,5,7.
    run_op(2'b01, 3'd0, 1'b0, 8'hA5, dc);
    exp_st[0] = 3'd0; exp_st[1] = 3'd2; exp_st[2] = 3'd5; exp_st[3] = 3'd7;
    chk("byte_a5_done", dc, 13);
    chk("byte_a5_strobes", n_str, 4);
    for (int i = 0; i < 4; i++) chk("byte_a5_order", st_a[i], exp_st[i]);
    chk("byte_a5_q", q, 8'hA5);

    run_op(2'b10, 3'd0, 1'b0, 8'h00, dc);
    chk("clear2_done", dc, 3);

    // Back-to-back: req held through the done cycle; input change mid-op ignored.
    req = 1'b1; op = 2'b00; waddr = 3'd1; bitval = 1'b1;
    @(posedge clk);
    @(negedge clk);
    waddr = 3'd2;
    dc = -1;
    for (int n = 1; n < 16; n++) begin
      if (n == 2) chk("b2b_first_addr", a_m, 1);
      if (done_m) begin
        dc = n;
        break;
      end
      @(negedge clk);
    end
    chk("b2b_first_done", dc, 4);
    @(negedge clk);
    chk("b2b_second_accepted", ready_m, 0);
    chk("b2b_second_addr", a_m, 2);
    req = 1'b0;
    dc = -1;
    for (int n = 2; n < 16; n++) begin
      @(negedge clk);
      if (done_m) begin
        dc = n;
        break;
      end
    end
    chk("b2b_second_done", dc, 4);
    chk("b2b_shadow", sh_m, 8'h06);

    // Random mix against a shadow model.
    m_sh = 8'h06;
    for (int it = 0; it < 40; it++) begin
      r_o = 2'($urandom_range(0, 3));
      r_a = 3'($urandom_range(0, 7));
      r_b = 1'($urandom_range(0, 1));
      r_d = 8'($urandom_range(0, 255));
      k = 0;
      exp_dc = 1;
      if (r_o == 2'b10) begin
        exp_dc = 3;
        m_sh = 8'h00;
      end else if (r_o != 2'b11) begin
        m_val  = (r_o == 2'b00) ? {8{r_b}} : r_d;
        m_mask = (r_o == 2'b00) ? (8'b1 << r_a) : 8'hFF;
        m_mask = m_mask & (m_val ^ m_sh);
        k = $countones(m_mask);
        exp_dc = (k == 0) ? 1 : 3 * k + 1;
        m_sh = (m_sh & ~m_mask) | (m_val & m_mask);
      end
      run_op(r_o, r_a, r_b, r_d, dc);
      chk("rnd_done", dc, exp_dc);
      chk("rnd_strobes", n_str, k);
      chk("rnd_shadow", sh_m, m_sh);
      chk("rnd_q", q, m_sh);
    end

    // Reset during the strobe of bit 3 of a byte write.
    run_op(2'b10, 3'd0, 1'b0, 8'h00, dc);
    req = 1'b1; op = 2'b01; wdata = 8'h0F;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    for (int n = 2; n <= 11; n++) @(negedge clk);
    chk("abort_in_strobe", eb_m, 0);
    chk("abort_strobe_addr", a_m, 3);
    apply_reset(1'b0);

    // Instance without skipping: an unchanged byte still takes 8 strobes.
    apply_reset(1'b1);
    run_op(2'b01, 3'd0, 1'b0, 8'hA5, dc);
    chk("noskip_first_done", dc, 25);
    chk("noskip_first_q", q, 8'hA5);
    run_op(2'b01, 3'd0, 1'b0, 8'hA5, dc);
    chk("noskip_same_done", dc, 25);
    chk("noskip_same_strobes", n_str, 8);
    for (int i = 0; i < 8; i++) chk("noskip_order", st_a[i], i);
    chk("noskip_shadow", sh_m, 8'hA5);

    @(negedge clk);
    chk("inv_ad_stable", viol_ad, 0);
    chk("inv_eb_clrb", viol_both, 0);
    chk("inv_shadow_q", viol_sh, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
